// File: rtl/div_datapath_ctrl.sv
// Unsigned divider by repeated subtraction: FSM controller and datapath in one block.
// Operands share data_in (dividend, then divisor); results stay registered until the next load.
module div_datapath_ctrl #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start,
  input  logic [W-1:0] data_in,
  output logic [W-1:0] quotient,
  output logic [W-1:0] remainder,
  output logic         div_by_zero,
  output logic         busy,
  output logic         done
);

  // state | meaning
  // IDLE  | waiting for start; last results held
  // LD_A  | capture dividend into R, clear Q and div_by_zero
  // LD_B  | capture divisor into D
  // CHECK | divisor zero / R<D short-cut / begin subtracting
  // SUB   | R-=D, Q+=1 per cycle until R<D
  // DONE  | one-cycle done pulse
  typedef enum logic [2:0] {
    S_IDLE, S_LD_A, S_LD_B, S_CHECK, S_SUB, S_DONE
  } state_t;

  state_t       state_q, state_d;
  logic [W-1:0] q_q, q_d;
  logic [W-1:0] r_q, r_d;
  logic [W-1:0] dvs_q, dvs_d;
  logic         dbz_q, dbz_d;
  logic         busy_q, busy_d;
  logic         done_q, done_d;
  logic [W:0]   diff;

  // Borrow out of a W+1-bit subtract is the a<b flag.
  function automatic logic lt_by_sub(input logic [W-1:0] a, input logic [W-1:0] b);
    return 1'(({1'b0, a} - {1'b0, b}) >> W);
  endfunction

  assign diff = {1'b0, r_q} - {1'b0, dvs_q};

  always_comb begin
    state_d = state_q;
    q_d     = q_q;
    r_d     = r_q;
    dvs_d   = dvs_q;
    dbz_d   = dbz_q;
    case (state_q)
      S_IDLE:  if (start) state_d = S_LD_A;
      S_LD_A: begin
        r_d     = data_in;
        q_d     = '0;
        dbz_d   = 1'b0;
        state_d = S_LD_B;
      end
      S_LD_B: begin
        dvs_d   = data_in;
        state_d = S_CHECK;
      end
      S_CHECK: begin
        if (dvs_q == '0) begin
          q_d     = '1;
          dbz_d   = 1'b1;
          state_d = S_DONE;
        end else if (diff[W]) begin
          state_d = S_DONE;
        end else begin
          state_d = S_SUB;
        end
      end
      S_SUB: begin
        r_d = diff[W-1:0];
        q_d = q_q + 1'b1;
        // Look ahead on the updated remainder so Q never overshoots.
        if (lt_by_sub(diff[W-1:0], dvs_q)) state_d = S_DONE;
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
    busy_d = (state_d != S_IDLE);
    done_d = (state_d == S_DONE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      q_q     <= '0;
      r_q     <= '0;
      dvs_q   <= '0;
      dbz_q   <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      q_q     <= q_d;
      r_q     <= r_d;
      dvs_q   <= dvs_d;
      dbz_q   <= dbz_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign quotient    = q_q;
  assign remainder   = r_q;
  assign div_by_zero = dbz_q;
  assign busy        = busy_q;
  assign done        = done_q;

endmodule

// File: tb/tb_div_datapath_ctrl.sv
// Directed bench for div_datapath_ctrl: arithmetic model of quotient/remainder/latency,
// checked every cycle, plus literal pins of selected results.
module tb_div_datapath_ctrl;
  localparam int W = 16;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         start = 1'b0;
  logic [W-1:0] data_in = '0;
  logic [W-1:0] quotient, remainder;
  logic         div_by_zero, busy, done;

  int checks = 0;
  int failures = 0;

  // model state
  bit           active = 1'b0;
  bit           out_valid = 1'b0;
  int           edge_cnt = 0;
  int           lat = 0;
  logic [W-1:0] exp_q = '0, exp_r = '0;
  logic         exp_z = 1'b0;

  div_datapath_ctrl #(.W(W)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .data_in(data_in),
    .quotient(quotient), .remainder(remainder), .div_by_zero(div_by_zero),
    .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d (edge %0d)", name, act, exp, edge_cnt);
    end
  endtask

  // Compare process: edges counted from the edge that samples start (edge 0).
  always @(posedge clk) begin
    if (active) edge_cnt++;
    #1;
    if (active) begin
      chk("done", done, 32'(edge_cnt == lat));
      chk("busy", busy, 32'(edge_cnt <= lat));
      if (edge_cnt >= lat) begin
        chk("quotient", quotient, exp_q);
        chk("remainder", remainder, exp_r);
        chk("div_by_zero", div_by_zero, exp_z);
      end
    end else if (out_valid) begin
      chk("idle_done", done, 0);
      chk("idle_busy", busy, 0);
      chk("held_quotient", quotient, exp_q);
      chk("held_remainder", remainder, exp_r);
      chk("held_div_by_zero", div_by_zero, exp_z);
    end
  end

  task automatic begin_op(input int a, input int b);
    @(negedge clk);
    if (b == 0) begin
      exp_q = '1; exp_r = W'(a); exp_z = 1'b1; lat = 3;
    end else begin
      exp_q = W'(a / b); exp_r = W'(a % b); exp_z = 1'b0;
      lat = (a / b == 0) ? 3 : 3 + a / b;
    end
    start = 1'b1; data_in = W'($urandom);
    out_valid = 1'b0; edge_cnt = -1; active = 1'b1;
    @(negedge clk); start = 1'b0; data_in = W'(a);
    @(negedge clk); data_in = W'(b);
    @(negedge clk); data_in = W'($urandom);
  endtask

  // Runs to one cycle past DONE; start is pulsed at the negedges where edge_cnt==p1/p2.
  task automatic finish_op(input int p1, input int p2);
    while (edge_cnt <= lat) begin
      @(negedge clk);
      start = (edge_cnt == p1) || (edge_cnt == p2);
      data_in = W'($urandom);
    end
    start = 1'b0;
    active = 1'b0;
    out_valid = 1'b1;
  endtask

  initial begin
    repeat (2) @(negedge clk);
    chk("rst_quotient", quotient, 0);
    chk("rst_remainder", remainder, 0);
    chk("rst_div_by_zero", div_by_zero, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    rst_n = 1'b1;
    @(negedge clk);

    begin_op(17, 5); finish_op(-10, -10);
    chk("lit_17_5_lat", lat, 6);
    chk("lit_17_5_q", quotient, 3);
    chk("lit_17_5_r", remainder, 2);
    chk("lit_17_5_z", div_by_zero, 0);

    begin_op(3, 7); finish_op(-10, -10);
    chk("lit_3_7_q", quotient, 0);
    chk("lit_3_7_r", remainder, 3);

    begin_op(100, 0); finish_op(-10, -10);
    chk("lit_100_0_q", quotient, 16'hFFFF);
    chk("lit_100_0_r", remainder, 100);
    chk("lit_100_0_z", div_by_zero, 1);

    begin_op(12, 12); finish_op(-10, -10);
    chk("lit_12_12_lat", lat, 4);
    chk("lit_12_12_q", quotient, 1);
    chk("lit_12_12_r", remainder, 0);

    begin_op(65535, 1); finish_op(-10, -10);
    chk("lit_65535_1_lat", lat, 65538);
    chk("lit_65535_1_q", quotient, 65535);
    chk("lit_65535_1_r", remainder, 0);

    // start pulses sampled in SUB and in DONE must be ignored
    begin_op(20, 3); finish_op(5, 9);
    repeat (3) @(negedge clk);
    chk("lit_ignore_q", quotient, 6);
    chk("lit_ignore_r", remainder, 2);

    // reset mid-SUB aborts with no done pulse
    begin_op(50, 2);
    repeat (4) @(negedge clk);
    rst_n = 1'b0;
    active = 1'b0;
    #1;
    chk("abort_quotient", quotient, 0);
    chk("abort_remainder", remainder, 0);
    chk("abort_div_by_zero", div_by_zero, 0);
    chk("abort_busy", busy, 0);
    chk("abort_done", done, 0);
    exp_q = '0; exp_r = '0; exp_z = 1'b0; out_valid = 1'b1;
    @(negedge clk); rst_n = 1'b1;
    repeat (3) @(negedge clk);

    begin_op(9, 2); finish_op(-10, -10);
    chk("lit_9_2_q", quotient, 4);
    chk("lit_9_2_r", remainder, 1);

    repeat (2) @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
